bus_rr_scheduler: RTL and testbench
===================================

// Module: bus_rr_scheduler
// PURPOSE
// - Arbitration/sequencing controller for the shared bus between DRVRS driver FIFOs.
// - Watches each driver's pending flag and grants one source at a time, round-robin.
// - Pops the granted driver's head packet and pushes it to the addressed destination,
//   or to all other drivers on broadcast. Drops packets with a bad address and counts them.
// - Drives the same pndng/pop/D_pop/push/D_push signal set the driver FIFOs expose.
// PARAMETERS
// - pckg_sz  16  packet width in bits; destination ID = D_pop[pckg_sz-1 -: 8]
// - drvrs     8  number of drivers; 2..254
// - bcast  8'hFF destination ID meaning broadcast
// PORTS
// - clk        in   1               clock, all logic on posedge
// - reset      in   1               synchronous, active-low
// - pndng      in   drvrs           driver d has a packet at FIFO head
// - D_pop      in   drvrs*pckg_sz   head packet of driver d at bits [d*pckg_sz +: pckg_sz], valid while pndng[d]
// - pop        out  drvrs           one-hot, one-cycle pop strobe to the granted driver
// - push       out  drvrs           push strobes to destination driver(s)
// - D_push     out  pckg_sz         packet delivered, shared by all destinations, valid with push
// - busy       out  1               FSM not in IDLE
// - drop_cnt   out  16              count of dropped packets, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - pop=0, push=0, D_push=0, busy=0, drop_cnt=0.
//   - FSM returns to IDLE; rr_ptr=drvrs-1, so the first search starts at driver 0.
//   - Applies mid-transfer: any in-flight packet is discarded and no strobe occurs on the next cycle.
// - FSM, states IDLE -> GRANT -> DELIVER -> IDLE:
//   - IDLE: if |pndng, register grant g = first set bit at or after (rr_ptr+1) mod drvrs,
//     wrapping; go to GRANT. Otherwise stay in IDLE.
//   - GRANT: if pndng[g]==1: pop[g]=1 for exactly this cycle, capture D_pop[g] into data_q,
//     go to DELIVER. If pndng[g]==0: abort to IDLE, no pop, rr_ptr unchanged.
//   - DELIVER: decode id=data_q[pckg_sz-1 -: 8] and drive D_push=data_q.
//     - id==bcast: push = all ones except bit g.
//     - id<drvrs and id!=g: push = one-hot id.
//     - otherwise (id>=drvrs non-bcast, or self-address): push=0, drop_cnt +1 (saturating).
//     - rr_ptr<=g in all three cases; next state is IDLE.
// - Latency and throughput:
//   - Pop strobe 1 cycle after IDLE detects pending; push strobe 1 cycle after the pop.
//   - 3 cycles per packet; max throughput 1 packet per 3 cycles.
// - Strobe rules:
//   - pop is at most one-hot.
//   - pop and push are never high in the same cycle.
//   - D_push holds its last value when push==0.
// - Fairness: a continuously pending driver is granted within drvrs packets; no starvation.
// - pndng changes while in DELIVER have no effect until the next IDLE.
// STRUCTURE
// - Package bus_sched_pkg holds:
//   - typedef enum logic [1:0] {IDLE, GRANT, DELIVER} sched_state_t
//   - localparam ID_W=8; localparam BCAST_ID=8'hFF
//   - function dest_mask(id, src, n) returning the push vector
// - Sub-module rr_pick #(N): combinational round-robin priority pick.
//   - Inputs req[N], ptr; outputs gnt_idx, any.
//   - Implemented as a double-width request vector masked by ptr.
// - Top level holds the FSM, data_q, rr_ptr, grant register and drop counter.
// TESTING
// - Single: pndng=8'h04, D_pop[2]=16'h05AB -> pop=8'h04 at cycle 2;
//   push=8'h20 and D_push=16'h05AB at cycle 3; drop_cnt=0.
// - Round-robin: pndng=8'hFF held, all targeting driver 7 except driver 7's own packets,
//   which target driver 0 -> grant order 0,1,2,...,7,0 and every push is one-hot.
// - Broadcast: driver 3 sends 16'hFF12 -> push=8'hF7, D_push=16'hFF12.
// - Drops: driver 1 sends id 8'h09, then id 8'h01 -> push stays 0 both times; drop_cnt=2.
// - Abort: pndng[4] falls during GRANT -> no pop or push; next grant search still starts at rr_ptr+1.
// - Reset mid-op: reset=0 during DELIVER -> no push next cycle; all outputs 0, busy=0;
//   the first grant after reset is driver 0.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
package bus_sched_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, DELIVER} sched_state_t;

    localparam int unsigned ID_W      = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
    localparam int unsigned MAX_DRVRS = 256;

    // Push vector for a packet addressed to id from src among n drivers; all-zero means drop.
    function automatic logic [MAX_DRVRS-1:0] dest_mask(input logic [ID_W-1:0] id,
                                                       input logic [ID_W-1:0] src,
                                                       input int unsigned     n,
                                                       input logic [ID_W-1:0] bc = BCAST_ID);
        logic [MAX_DRVRS-1:0] m;
        m = '0;
        if (id == bc) begin
            for (int unsigned i = 0; i < MAX_DRVRS; i++) begin
                if (i < n) m[i] = 1'b1;
            end
            m[src] = 1'b0;
        end else if (({24'b0, id} < n) && (id != src)) begin
            m[id] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/bus_rr_scheduler_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr+1, wrapping.
module rr_pick #(
    parameter int unsigned N = 8,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] masked;
    int unsigned    pick;
    logic           found;

    // Upper copy of req supplies the wrapped-around candidates.
    always_comb begin
        dbl_req = {req, req};
        masked  = '0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            masked[i] = dbl_req[i] && (i > 32'(ptr));
        end
        pick  = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (masked[i] && !found) begin
                pick  = i;
                found = 1'b1;
            end
        end
        gnt_idx = (pick >= N) ? IW'(pick - N) : IW'(pick);
        any     = |req;
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin bus scheduler: grants one driver FIFO, pops its head and pushes it to the
// addressed driver(s), dropping and counting badly addressed packets.
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int unsigned pckg_sz = 16,
    parameter int unsigned drvrs   = 8,
    parameter logic [7:0]  bcast   = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic                     busy,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned IW = $clog2(drvrs);

    sched_state_t         state_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        grant_q;
    logic [pckg_sz-1:0]   data_q;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [ID_W-1:0]      dest_id;
    logic [MAX_DRVRS-1:0] mask_full;
    logic [drvrs-1:0]     dest;

    rr_pick #(
        .N(drvrs)
    ) u_pick (
        .req    (pndng),
        .ptr    (rr_ptr_q),
        .gnt_idx(pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        dest_id   = data_q[pckg_sz-1 -: ID_W];
        mask_full = dest_mask(dest_id, ID_W'(grant_q), drvrs, bcast);
        dest      = mask_full[drvrs-1:0];
    end

    // pop must follow pndng within the GRANT cycle so a withdrawn request never pops.
    always_comb begin
        pop = '0;
        if (state_q == GRANT && pndng[grant_q]) pop[grant_q] = 1'b1;
        push   = (state_q == DELIVER) ? dest : '0;
        D_push = data_q;
        busy   = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= IW'(drvrs - 1);
            grant_q  <= '0;
            data_q   <= '0;
            drop_cnt <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (pndng[grant_q]) begin
                        data_q  <= D_pop[32'(grant_q) * pckg_sz +: pckg_sz];
                        state_q <= DELIVER;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DELIVER: begin
                    if (dest == '0 && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                    rr_ptr_q <= grant_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Self-checking bench for bus_rr_scheduler: directed table, corner sequences, random FIFO traffic.
module tb_bus_rr_scheduler;

    localparam int N = 8;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   pndng;
    logic [N*W-1:0] D_pop;
    logic [N-1:0]   pop;
    logic [N-1:0]   push;
    logic [W-1:0]   D_push;
    logic           busy;
    logic [15:0]    drop_cnt;

    bus_rr_scheduler #(
        .pckg_sz(W),
        .drvrs  (N),
        .bcast  (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pndng   (pndng),
        .D_pop   (D_pop),
        .pop     (pop),
        .push    (push),
        .D_push  (D_push),
        .busy    (busy),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [15:0] pkt;
        logic [7:0]  exp_push;
        int          exp_drop;
    } vec_t;

    vec_t        vecs[7];
    int          total = 0;
    int          bad = 0;
    int          exp_last;
    int          exp_drop;
    logic [15:0] fmem[N][32];
    int          fhead[N];
    int          ftail[N];
    logic [7:0]  s_pop;
    logic [7:0]  s_push;
    logic [15:0] s_dpush;
    logic        s_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        s_pop   = pop;
        s_push  = push;
        s_dpush = D_push;
        s_busy  = busy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] onehot(input int d);
        logic [7:0] r;
        r    = '0;
        r[d] = 1'b1;
        return r;
    endfunction

    // Destination rule straight from the addressing description.
    function automatic logic [7:0] exp_mask(input logic [15:0] pkt, input int src);
        int         id;
        logic [7:0] m;
        id = int'(pkt[15:8]);
        m  = '0;
        if (id == 255) begin
            m      = 8'hFF;
            m[src] = 1'b0;
        end else if (id < N && id != src) begin
            m[id] = 1'b1;
        end
        return m;
    endfunction

    task automatic clear_fifos();
        for (int d = 0; d < N; d++) begin
            fhead[d] = 0;
            ftail[d] = 0;
        end
    endtask

    task automatic push_pkt(input int d, input logic [15:0] pkt);
        fmem[d][ftail[d]] = pkt;
        ftail[d]++;
    endtask

    function automatic bit fifos_empty();
        for (int d = 0; d < N; d++) if (fhead[d] != ftail[d]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int rr_next(input int last);
        for (int k = 1; k <= N; k++) begin
            if (fhead[(last + k) % N] != ftail[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int d = 0; d < N; d++) begin
            pndng[d] = (fhead[d] != ftail[d]);
            D_pop[d*W +: W] = pndng[d] ? fmem[d][fhead[d]] : 16'h0000;
        end
    endtask

    task automatic drain(input int budget);
        int          exp_src;
        int          want_src;
        bit          want_push;
        logic [15:0] want_pkt;
        logic [7:0]  m;
        want_src  = 0;
        want_push = 1'b0;
        want_pkt  = '0;
        for (int c = 0; c < budget; c++) begin
            if (fifos_empty() && !want_push) break;
            drive_inputs();
            exp_src = rr_next(exp_last);
            cycle();
            if (want_push) begin
                m = exp_mask(want_pkt, want_src);
                chk("deliver_push", 32'(s_push), 32'(m));
                chk("deliver_data", 32'(s_dpush), 32'(want_pkt));
                chk("deliver_no_pop", 32'(s_pop), 32'h0);
                if (m == '0) exp_drop++;
                exp_last  = want_src;
                want_push = 1'b0;
            end else begin
                chk("grant_no_push", 32'(s_push), 32'h0);
                if (s_pop != '0) begin
                    if (exp_src < 0) begin
                        chk("spurious_pop", 32'(s_pop), 32'h0);
                    end else begin
                        chk("grant_src", 32'(s_pop), 32'(onehot(exp_src)));
                        want_src  = exp_src;
                        want_pkt  = fmem[exp_src][fhead[exp_src]];
                        fhead[exp_src]++;
                        want_push = 1'b1;
                    end
                end
            end
        end
        if (!fifos_empty() || want_push) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got packets left want none");
        end
        drive_inputs();
        chk("drain_idle", 32'(busy), 32'h0);
        chk("drain_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    endtask

    initial begin
        vecs[0] = '{src: 2, pkt: 16'h05AB, exp_push: 8'h20, exp_drop: 0};
        vecs[1] = '{src: 3, pkt: 16'hFF12, exp_push: 8'hF7, exp_drop: 0};
        vecs[2] = '{src: 1, pkt: 16'h0912, exp_push: 8'h00, exp_drop: 1};
        vecs[3] = '{src: 1, pkt: 16'h0134, exp_push: 8'h00, exp_drop: 2};
        vecs[4] = '{src: 0, pkt: 16'h0700, exp_push: 8'h80, exp_drop: 2};
        vecs[5] = '{src: 7, pkt: 16'h0055, exp_push: 8'h01, exp_drop: 2};
        vecs[6] = '{src: 5, pkt: 16'h0801, exp_push: 8'h00, exp_drop: 3};

        clear_fifos();
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        repeat (3) cycle();
        chk("reset_pop", 32'(pop), 32'h0);
        chk("reset_push", 32'(push), 32'h0);
        chk("reset_dpush", 32'(D_push), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_drop", 32'(drop_cnt), 32'h0);
        reset    = 1'b1;
        exp_last = N - 1;
        exp_drop = 0;

        foreach (vecs[i]) begin
            pndng = onehot(vecs[i].src);
            D_pop = '0;
            D_pop[vecs[i].src*W +: W] = vecs[i].pkt;
            cycle();
            chk("tbl_idle_pop", 32'(s_pop), 32'h0);
            cycle();
            chk("tbl_pop", 32'(s_pop), 32'(onehot(vecs[i].src)));
            chk("tbl_pop_no_push", 32'(s_push), 32'h0);
            pndng = '0;
            cycle();
            chk("tbl_push", 32'(s_push), 32'(vecs[i].exp_push));
            chk("tbl_dpush", 32'(s_dpush), 32'(vecs[i].pkt));
            chk("tbl_busy", 32'(s_busy), 32'h1);
            chk("tbl_drop", 32'(drop_cnt), 32'(vecs[i].exp_drop));
            chk("tbl_done_idle", 32'(busy), 32'h0);
            exp_last = vecs[i].src;
            exp_drop = vecs[i].exp_drop;
        end

        // Everyone pending: drivers target 7, driver 7 targets 0.
        clear_fifos();
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < N; d++) push_pkt(d, (d == N - 1) ? 16'h0011 : 16'h0722);
        end
        drain(80);

        // Request withdrawn during GRANT: no strobes, pointer untouched.
        clear_fifos();
        pndng = 8'h10;
        D_pop = '0;
        D_pop[4*W +: W] = 16'h0200;
        cycle();
        chk("abort_idle_pop", 32'(s_pop), 32'h0);
        pndng = '0;
        cycle();
        chk("abort_no_pop", 32'(s_pop), 32'h0);
        chk("abort_busy", 32'(s_busy), 32'h1);
        cycle();
        chk("abort_no_push", 32'(s_push), 32'h0);
        push_pkt(2, 16'h0300);
        push_pkt(6, 16'h0100);
        drain(20);

        // Reset while delivering.
        clear_fifos();
        pndng = 8'h20;
        D_pop = '0;
        D_pop[5*W +: W] = 16'h0100;
        cycle();
        cycle();
        chk("rst_op_pop", 32'(s_pop), 32'h20);
        pndng = '0;
        reset = 1'b0;
        cycle();
        chk("rst_op_deliver", 32'(s_push), 32'h02);
        chk("rst_op_pop_after", 32'(pop), 32'h0);
        chk("rst_op_push_after", 32'(push), 32'h0);
        chk("rst_op_dpush_after", 32'(D_push), 32'h0);
        chk("rst_op_busy_after", 32'(busy), 32'h0);
        chk("rst_op_drop_after", 32'(drop_cnt), 32'h0);
        reset    = 1'b1;
        exp_last = N - 1;
        exp_drop = 0;
        push_pkt(0, 16'h0300);
        push_pkt(6, 16'h0100);
        drain(20);

        for (int r = 0; r < 20; r++) begin
            int npk;
            clear_fifos();
            npk = 0;
            for (int d = 0; d < N; d++) begin
                int cnt;
                cnt = int'($urandom_range(0, 3));
                for (int k = 0; k < cnt; k++) begin
                    logic [7:0] id;
                    case ($urandom_range(0, 3))
                        0:       id = 8'($urandom_range(0, N - 1));
                        1:       id = 8'hFF;
                        2:       id = 8'(d);
                        default: id = 8'($urandom_range(N, 254));
                    endcase
                    push_pkt(d, {id, 8'($urandom)});
                    npk++;
                end
            end
            drain(3 * npk + 10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
